pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Next-PC control for the 6-bit program counter register. Drives that register's load strobe and load value each cycle and reads its current value back.
- Supports increment, absolute jump, call/return through a small return-address stack, halt/resume and stall.
- Sits between the instruction decoder (command inputs) and the PC register. It writes the PC; the register only holds it.

Parameters:
- WIDTH, 6, PC width in bits; all PC arithmetic is modulo 2^WIDTH.
- DEPTH, 4, return-stack entries; must be a power of 2, minimum 2.
- RESET_VEC, 6'd0, value loaded into the PC while rst is high.
- TRAP_VEC, 6'd63, vector used only when STACK_TRAP_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- pc_in  in  WIDTH  current PC; the PC register's output.
- stall  in  1  freeze: no load, no state or stack change.
- jmp  in  1  absolute jump to target.
- call  in  1  push return address, jump to target.
- ret  in  1  pop return address into the PC.
- halt  in  1  enter HALT.
- resume  in  1  leave HALT.
- target  in  WIDTH  jump/call destination.
- ld  out  1  load strobe to the PC register.
- Lvalue  out  WIDTH  next-PC value to the PC register.
- sp  out  clog2(DEPTH)+1  stack occupancy, 0..DEPTH.
- halted  out  1  high in HALT.
- stack_err  out  1  sticky; set on stack overflow or underflow.

Behaviour:
- Output timing:
  - ld and Lvalue are combinational from state, stack and inputs.
  - The PC register captures Lvalue at the same edge, so the new PC is visible on pc_in one cycle after the command.
  - Zero added latency.
- While rst is high:
  - ld=1, Lvalue=RESET_VEC, so the PC loads the vector at that edge.
  - State goes to RUN; sp=0, halted=0, stack_err=0 (registered, valid the cycle after the rst edge).
  - Stack contents are don't-care.
  - Reset mid-call, mid-halt or in ERR always wins.
- States: RUN, HALT, ERR; 2-bit encoding.
- RUN, commands are evaluated in this priority order; the first match applies:
  1. stall: ld=0; all commands ignored.
  2. halt: ld=0; next state HALT.
  3. ret:
     - sp=0 (underflow): ld=0, stack_err set, next state ERR.
     - Otherwise: ld=1, Lvalue=stack[sp-1], sp decrements.
  4. call:
     - sp=DEPTH (overflow): ld=0, stack_err set, next state ERR.
     - Otherwise: push (pc_in+1) mod 2^WIDTH into stack[sp], sp increments, ld=1, Lvalue=target.
  5. jmp: ld=1, Lvalue=target.
  6. None of the above (increment): ld=1, Lvalue=(pc_in+1) mod 2^WIDTH; 63 wraps to 0.
- Simultaneous commands: lower-priority commands in the same cycle are discarded, not queued. Example: call+ret with sp=2 performs only the pop; sp becomes 1.
- HALT:
  - ld=0; halted=1.
  - resume with stall low: next state RUN, ld=0 in this cycle; incrementing restarts the following cycle.
  - stall masks resume.
  - Other commands are ignored.
- ERR: ld=0; only rst exits.
- sp never exceeds DEPTH and never goes below 0.
- The stack is a register array indexed by sp; no wrap of the stack pointer.

Optional Feature:
- Macro: PC_SEQ_STACK_TRAP_EN.
- Defined:
  - Overflow/underflow does not enter ERR.
  - ld=1, Lvalue=TRAP_VEC; sp is cleared to 0; stack_err is set sticky.
  - State stays RUN; ERR is unreachable.
- Undefined: ERR behaviour as above; TRAP_VEC is unused.

Decomposition:
- Shared package pc_seq_pkg holds:
  - the state encoding constants (ST_RUN=2'd0, ST_HALT=2'd1, ST_ERR=2'd2);
  - PC width default 6;
  - RESET_VEC and TRAP_VEC defaults.
- One natural sub-module: ret_stack, a LIFO with push/pop, sp, full and empty. The sequencer instantiates it and owns all control and priority.

Test Plan:
- Reset, then free run from pc=0 for 70 cycles -> ld=1 every cycle, Lvalue steps 1,2,…,63,0,1 (wrap at 63).
- At pc=5 call target=20; at pc=22 ret -> Lvalue=20 with sp=1, then Lvalue=6 with sp=0.
- Five nested calls with DEPTH=4 -> fifth call gives ld=0, stack_err=1, state ERR, ld held 0. With PC_SEQ_STACK_TRAP_EN: Lvalue=63, sp=0, state stays RUN.
- ret with sp=0 -> stack_err=1, ld=0; then assert rst -> Lvalue=0, ld=1; stack_err=0 and sp=0 the next cycle.
- halt at pc=10 -> ld=0 and pc holds 10 for 5 cycles; resume+stall has no effect; resume alone -> one idle cycle, then Lvalue=11.
- Same cycle stall+jmp target=40 at pc=3 -> ld=0, pc stays 3. Then jmp+call target=40 at pc=3 -> call taken: sp=1, stacked value 4, Lvalue=40.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: state encoding and
// default PC width / vectors.
package pc_seq_pkg;
  localparam int PC_W = 6;
  localparam logic [PC_W-1:0] RESET_VEC_DEF = 6'd0;
  localparam logic [PC_W-1:0] TRAP_VEC_DEF  = 6'd63;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;
endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. sp counts occupied entries (0..DEPTH); it never
// wraps. Pushes when full and pops when empty are ignored here, the
// sequencer decides what an overflow/underflow means.
module ret_stack #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top_data,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [AW-1:0]    wr_idx, rd_idx;

  // Low bits of sp address the next free slot; top-of-stack is one below
  // (at sp=DEPTH the low bits are 0, so rd_idx wraps to DEPTH-1 as wanted).
  assign wr_idx   = sp_q[AW-1:0];
  assign rd_idx   = wr_idx - AW'(1);
  assign top_data = mem_q[rd_idx];
  assign sp       = sp_q;
  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);

  // Next stack contents and pointer; clear beats push beats pop.
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (clr) begin
      sp_d = '0;
    end else if (push && !full) begin
      mem_d[wr_idx] = push_data;
      sp_d          = sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  // Pointer register; only the pointer needs a reset value.
  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Stack storage; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Next-PC control for the PC register: increment, jump, call/return,
// halt/resume, stall. ld/Lvalue are combinational so the PC register
// takes the new value on the same edge as the command.
// Optional build macro PC_SEQ_STACK_TRAP_EN: stack overflow/underflow
// vectors to TRAP_VEC and clears the stack instead of entering ERR.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = PC_W,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(TRAP_VEC_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       pc_in,
  input  logic                   stall,
  input  logic                   jmp,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   halt,
  input  logic                   resume,
  input  logic [WIDTH-1:0]       target,
  output logic                   ld,
  output logic [WIDTH-1:0]       Lvalue,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   halted,
  output logic                   stack_err
);
  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic             push, pop, clr, fault;
  logic             full, empty;
  logic [WIDTH-1:0] top_data;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc    = pc_in + WIDTH'(1);
  assign halted    = (state_q == ST_HALT);
  assign stack_err = err_q;

`ifndef PC_SEQ_STACK_TRAP_EN
  // Trap vector only matters in the trap build.
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clr       (clr),
    .push_data (pc_inc),
    .top_data  (top_data),
    .sp        (sp),
    .full      (full),
    .empty     (empty)
  );

  // Command priority in RUN: stall > halt > ret > call > jmp > increment.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ld      = 1'b0;
    Lvalue  = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    fault   = 1'b0;
    if (rst) begin
      ld     = 1'b1;
      Lvalue = RESET_VEC;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stall) begin
            ld = 1'b0;
          end else if (halt) begin
            state_d = ST_HALT;
          end else if (ret) begin
            if (empty) fault = 1'b1;
            else begin
              ld     = 1'b1;
              Lvalue = top_data;
              pop    = 1'b1;
            end
          end else if (call) begin
            if (full) fault = 1'b1;
            else begin
              ld     = 1'b1;
              Lvalue = target;
              push   = 1'b1;
            end
          end else if (jmp) begin
            ld     = 1'b1;
            Lvalue = target;
          end else begin
            ld     = 1'b1;
            Lvalue = pc_inc;
          end
        end
        ST_HALT: begin
          if (resume && !stall) state_d = ST_RUN;
        end
        default: begin
          // ERR (and the unused encoding) park here until reset.
          state_d = ST_ERR;
        end
      endcase

      if (fault) begin
        err_d = 1'b1;
`ifdef PC_SEQ_STACK_TRAP_EN
        ld     = 1'b1;
        Lvalue = TRAP_VEC;
        clr    = 1'b1;
`else
        state_d = ST_ERR;
`endif
      end
    end
  end

  // State and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end
endmodule
